sym_phase_sched: RTL and testbench
==================================

Name: sym_phase_sched

Overview:
- Symbol-timing scheduler placed after the RX RRC matched filters (I and Q), ahead of the demapper.
- Measures the 16-QAM decision error at each of the SPS sample phases over a fixed window, then locks onto the lowest-error phase.
- While locked, it decimates the stream to one symbol per SPS samples and emits slicer decisions.
- It keeps monitoring the locked phase and falls back to acquisition when quality degrades.

Parameters:
- DATA_W, 12: sample width, signed two's complement (sample_t).
- SPS, 4: samples per symbol; must be a power of 2, 2..8.
- LOG2_WIN, 6: log2 of the window length in symbols per phase (64).
- LVL_IN, 648: inner QAM level magnitude.
- LVL_OUT, 1943: outer QAM level magnitude.
- LOCK_THR, 300: maximum average per-symbol error (|eI|+|eQ|) for acquiring or holding lock.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  scheduler enable.
- din_I  in  DATA_W  matched-filter I sample, signed.
- din_Q  in  DATA_W  matched-filter Q sample, signed.
- din_valid  in  1  sample strobe.
- sym_I  out  DATA_W  raw I sample at the chosen phase.
- sym_Q  out  DATA_W  raw Q sample at the chosen phase.
- slice_I  out  2  I decision index.
- slice_Q  out  2  Q decision index.
- sym_valid  out  1  one-cycle symbol strobe.
- best_phase  out  $clog2(SPS)  selected phase.
- locked  out  1  lock status.
- err_metric  out  DATA_W  average error of the last completed window on the selected phase, unsigned.
- relock_cnt  out  8  lock-loss counter; saturates at 255.

Behaviour:
- Reset (async, rst=1): all outputs are 0; FSM goes to IDLE; phase counter, window counter and all accumulators are cleared. Outputs go to 0 immediately, without waiting for a clock edge.
- Slicer (combinational per component, level = L):
  - x < -1296: index 0, L = -LVL_OUT.
  - -1296 <= x < 0: index 1, L = -LVL_IN.
  - 0 <= x < 1296: index 2, L = +LVL_IN.
  - x >= 1296: index 3, L = +LVL_OUT.
  - Threshold 1296 = (LVL_IN+LVL_OUT+1)/2.
  - Error e = |x - L|. Maximum is 648 per component, so e_I+e_Q fits in 11 bits.
- Accumulators: SPS accumulators, each DATA_W+LOG2_WIN bits, unsigned. Sizing guarantees they never overflow, so no saturation logic is needed.
- Phase counter: increments modulo SPS on every din_valid while not IDLE. Cycles without din_valid change nothing.
- FSM, IDLE:
  - All accumulators are held at 0; locked=0.
  - en=1 → ACQ, starting with the phase counter at 0.
- FSM, ACQ:
  - On each din_valid, acc[phase] += e_I+e_Q.
  - When the window counter reaches 2^LOG2_WIN*SPS valid samples → DECIDE.
- FSM, DECIDE (1 cycle):
  - best = argmin(acc); ties resolve to the lowest index.
  - If acc[best] <= LOCK_THR<<LOG2_WIN: set best_phase=best, err_metric=acc[best]>>LOG2_WIN, locked=1, then → LOCK.
  - Otherwise: set err_metric the same way, then → ACQ.
  - Either way, clear the accumulators and the window counter. The phase counter continues without reset.
  - A din_valid arriving during DECIDE is counted by the phase counter but not accumulated.
- FSM, LOCK:
  - On a din_valid with phase==best_phase, register din_I/din_Q into sym_I/sym_Q and the slicer indices into slice_I/slice_Q, and assert sym_valid on the next cycle for exactly 1 cycle. Latency is 1 clock from the qualifying din_valid edge.
  - The error on best_phase is accumulated. After 2^LOG2_WIN symbols, err_metric is updated.
  - If the average exceeds LOCK_THR: locked=0, relock_cnt++ (saturating), → ACQ. The symbol emitted in that same cycle is still valid.
  - Otherwise the accumulator is cleared and the FSM stays in LOCK.
- en=0 in any state: → IDLE on the next edge; locked=0, sym_valid=0, accumulators cleared. relock_cnt and err_metric are held.
- sym_I, sym_Q, slice_I and slice_Q hold their values between strobes.
- sym_valid is never asserted outside LOCK.

Test Plan:
1. Clean lock:
   - Stimulus: random 16-QAM symbols, ±648/±1943 on sample phase 2, 0 on phases 0/1/3, din_valid every cycle.
   - Required: DECIDE after 256 valid samples, then best_phase=2, locked=1, err_metric=0.
   - Required: each sym_valid carries the exact symbol with the correct slice index, 1 cycle after its phase-2 sample.
2. Tie-break:
   - Stimulus: identical symbol value on all 4 phases.
   - Required: best_phase=0, locked=1.
3. No lock:
   - Stimulus: all samples 0, giving error 1296 per symbol, above LOCK_THR=300.
   - Required: locked stays 0, err_metric=1296, FSM repeatedly returns to ACQ, sym_valid never asserted.
4. Lock loss:
   - Stimulus: lock as in scenario 1, then drive phase 2 with ±1296 for 64 symbols.
   - Required: at window end locked=0, relock_cnt=1; re-lock after a further clean 256 samples.
5. Gapped input:
   - Stimulus: scenario 1 with din_valid asserted 1 cycle in 3.
   - Required: identical best_phase and symbol sequence; sym_valid spacing is 12 cycles.
6. Enable and reset:
   - Stimulus: drop en mid-ACQ.
   - Required: IDLE, accumulators 0, relock_cnt kept.
   - Stimulus: assert rst mid-LOCK, between clock edges.
   - Required: locked, sym_valid and relock_cnt read 0 before the next clock edge.

Source files
------------

// File: rtl/sym_phase_sched_if.sv
// Sample-in / symbol-out bundle between the matched filters, the phase scheduler and the demapper.
// master drives samples and enable; slave is the scheduler.
interface sym_phase_sched_if #(
  parameter int DATA_W = 12,
  parameter int SPS    = 4
);
  logic                       en;
  logic signed [DATA_W-1:0]   din_I;
  logic signed [DATA_W-1:0]   din_Q;
  logic                       din_valid;
  logic signed [DATA_W-1:0]   sym_I;
  logic signed [DATA_W-1:0]   sym_Q;
  logic [1:0]                 slice_I;
  logic [1:0]                 slice_Q;
  logic                       sym_valid;
  logic [$clog2(SPS)-1:0]     best_phase;
  logic                       locked;
  logic [DATA_W-1:0]          err_metric;
  logic [7:0]                 relock_cnt;

  modport master (
    output en, din_I, din_Q, din_valid,
    input  sym_I, sym_Q, slice_I, slice_Q, sym_valid, best_phase, locked, err_metric, relock_cnt
  );

  modport slave (
    input  en, din_I, din_Q, din_valid,
    output sym_I, sym_Q, slice_I, slice_Q, sym_valid, best_phase, locked, err_metric, relock_cnt
  );
endinterface

// File: rtl/sym_phase_sched.sv
// Symbol-timing scheduler: picks the sample phase with least 16-QAM slicer error, then decimates to it.
// Symbols leave 1 clock after the qualifying sample; the locked phase is re-checked every window.
module sym_phase_sched #(
  parameter int DATA_W   = 12,
  parameter int SPS      = 4,
  parameter int LOG2_WIN = 6,
  parameter int LVL_IN   = 648,
  parameter int LVL_OUT  = 1943,
  parameter int LOCK_THR = 300
) (
  input  logic             clk,
  input  logic             rst,
  sym_phase_sched_if.slave bus
);
  localparam int PW      = $clog2(SPS);
  localparam int ACC_W   = DATA_W + LOG2_WIN;
  localparam int E_W     = DATA_W + 1;
  localparam int WC_W    = LOG2_WIN + PW + 1;
  localparam int SLC_THR = (LVL_IN + LVL_OUT + 1) / 2;
  localparam logic [WC_W-1:0]  ACQ_LAST  = WC_W'((SPS << LOG2_WIN) - 1);
  localparam logic [WC_W-1:0]  LOCK_LAST = WC_W'((1 << LOG2_WIN) - 1);
  localparam logic [ACC_W-1:0] THR_ACC   = ACC_W'(LOCK_THR << LOG2_WIN);

  typedef enum logic [1:0] {IDLE, ACQ, DECIDE, LOCK} state_t;
  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic logic [1:0] slice_idx(input sample_t x);
    if (int'(x) < -SLC_THR)     return 2'd0;
    else if (int'(x) < 0)       return 2'd1;
    else if (int'(x) < SLC_THR) return 2'd2;
    else                        return 2'd3;
  endfunction

  function automatic logic [E_W-1:0] slice_err(input sample_t x, input logic [1:0] idx);
    int lvl;
    int d;
    case (idx)
      2'd0:    lvl = -LVL_OUT;
      2'd1:    lvl = -LVL_IN;
      2'd2:    lvl = LVL_IN;
      default: lvl = LVL_OUT;
    endcase
    d = int'(x) - lvl;
    return E_W'((d < 0) ? -d : d);
  endfunction

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [PW-1:0]       best_q, best_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [ACC_W-1:0]    acc_q [SPS];
  logic [ACC_W-1:0]    acc_d [SPS];
  sample_t             sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic [1:0]          slice_i_q, slice_i_d, slice_q_q, slice_q_d;
  logic                sym_valid_q, sym_valid_d;
  logic                locked_q, locked_d;
  logic [DATA_W-1:0]   err_q, err_d;
  logic [7:0]          relock_q, relock_d;

  logic [1:0]          sl_i, sl_q;
  logic [E_W-1:0]      e_sum;
  logic [ACC_W-1:0]    e_ext, min_acc, lock_sum;
  logic [PW-1:0]       min_idx;

  // Slicer and argmin; strict '<' keeps the lowest index on ties.
  always_comb begin
    sl_i    = slice_idx(bus.din_I);
    sl_q    = slice_idx(bus.din_Q);
    e_sum   = slice_err(bus.din_I, sl_i) + slice_err(bus.din_Q, sl_q);
    e_ext   = ACC_W'(e_sum);
    min_idx = '0;
    min_acc = acc_q[0];
    for (int i = 1; i < SPS; i++) begin
      if (acc_q[i] < min_acc) begin
        min_acc = acc_q[i];
        min_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    best_d      = best_q;
    wcnt_d      = wcnt_q;
    acc_d       = acc_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    slice_i_d   = slice_i_q;
    slice_q_d   = slice_q_q;
    sym_valid_d = 1'b0;
    locked_d    = locked_q;
    err_d       = err_q;
    relock_d    = relock_q;
    lock_sum    = acc_q[best_q] + e_ext;

    if (!bus.en) begin
      state_d  = IDLE;
      phase_d  = '0;
      wcnt_d   = '0;
      locked_d = 1'b0;
      for (int i = 0; i < SPS; i++) acc_d[i] = '0;
    end else begin
      if (state_q != IDLE && bus.din_valid) phase_d = phase_q + 1'b1;
      case (state_q)
        IDLE: begin
          state_d  = ACQ;
          phase_d  = '0;
          wcnt_d   = '0;
          locked_d = 1'b0;
          for (int i = 0; i < SPS; i++) acc_d[i] = '0;
        end
        ACQ: begin
          if (bus.din_valid) begin
            acc_d[phase_q] = acc_q[phase_q] + e_ext;
            wcnt_d         = wcnt_q + 1'b1;
            if (wcnt_q == ACQ_LAST) state_d = DECIDE;
          end
        end
        DECIDE: begin
          err_d  = min_acc[ACC_W-1:LOG2_WIN];
          wcnt_d = '0;
          for (int i = 0; i < SPS; i++) acc_d[i] = '0;
          if (min_acc <= THR_ACC) begin
            best_d   = min_idx;
            locked_d = 1'b1;
            state_d  = LOCK;
          end else begin
            state_d  = ACQ;
          end
        end
        default: begin
          if (bus.din_valid && phase_q == best_q) begin
            sym_i_d        = bus.din_I;
            sym_q_d        = bus.din_Q;
            slice_i_d      = sl_i;
            slice_q_d      = sl_q;
            sym_valid_d    = 1'b1;
            acc_d[best_q]  = lock_sum;
            wcnt_d         = wcnt_q + 1'b1;
            if (wcnt_q == LOCK_LAST) begin
              err_d         = lock_sum[ACC_W-1:LOG2_WIN];
              acc_d[best_q] = '0;
              wcnt_d        = '0;
              if (lock_sum > THR_ACC) begin
                locked_d = 1'b0;
                state_d  = ACQ;
                if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      best_q      <= '0;
      wcnt_q      <= '0;
      acc_q       <= '{default: '0};
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      slice_i_q   <= '0;
      slice_q_q   <= '0;
      sym_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      best_q      <= best_d;
      wcnt_q      <= wcnt_d;
      acc_q       <= acc_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      slice_i_q   <= slice_i_d;
      slice_q_q   <= slice_q_d;
      sym_valid_q <= sym_valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      relock_q    <= relock_d;
    end
  end

  assign bus.sym_I      = sym_i_q;
  assign bus.sym_Q      = sym_q_q;
  assign bus.slice_I    = slice_i_q;
  assign bus.slice_Q    = slice_q_q;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.best_phase = best_q;
  assign bus.locked     = locked_q;
  assign bus.err_metric = err_q;
  assign bus.relock_cnt = relock_q;
endmodule

// File: tb/tb_sym_phase_sched.sv
// Directed bench for sym_phase_sched: lock, tie-break, no-lock, lock loss, gapped input, enable and reset.
// Sample n (counted from ACQ entry) sits on phase n%4; symbol table entry (n/4)%64 feeds it.
module tb_sym_phase_sched;
  localparam int M_CLEAN = 0;
  localparam int M_TIE   = 1;
  localparam int M_ZERO  = 2;
  localparam int M_BAD   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sym_phase_sched_if #(.DATA_W(12), .SPS(4)) bus ();

  sym_phase_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n      = 0;
  int si [64];
  int sq [64];
  int last_sv;
  int sv_seen;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  function automatic int lvl(input int idx);
    case (idx)
      0:       return -1943;
      1:       return -648;
      2:       return 648;
      default: return 1943;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_I = '0;
    bus.din_Q = '0;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
  endtask

  task automatic start_acq();
    bus.en = 1'b1;
    bus.din_valid = 1'b0;
    tick();
    n = 0;
  endtask

  // chk_ph >= 0: expect a strobe after each sample on that phase and none elsewhere;
  // -2: expect no strobe at all; -1: no strobe checks.
  task automatic run_stream(input int mode, input int cnt, input int gap, input int chk_ph);
    int k, p, vi, vq, ei, eq;
    sv_seen = 0;
    last_sv = -1;
    for (int j = 0; j < cnt; j++) begin
      p  = n % 4;
      k  = (n / 4) % 64;
      vi = 0;
      vq = 0;
      ei = si[k];
      eq = sq[k];
      case (mode)
        M_CLEAN: if (p == 2) begin vi = lvl(si[k]); vq = lvl(sq[k]); end
        M_TIE:   begin vi = lvl(si[k]); vq = lvl(sq[k]); end
        M_BAD:   if (p == 2) begin vi = 1296; vq = -1296; ei = 3; eq = 1; end
        default: ;
      endcase
      bus.din_I = vi[11:0];
      bus.din_Q = vq[11:0];
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
      n++;
      if (chk_ph >= 0) begin
        if (p == chk_ph) begin
          check_eq("sym_valid", int'(bus.sym_valid), 1);
          check_eq("sym_I", int'(bus.sym_I), vi);
          check_eq("sym_Q", int'(bus.sym_Q), vq);
          check_eq("slice_I", int'(bus.slice_I), ei);
          check_eq("slice_Q", int'(bus.slice_Q), eq);
          if (last_sv >= 0) check_eq("sym_spacing", cyc - last_sv, 4 * (gap + 1));
          last_sv = cyc;
        end else begin
          check_eq("no_sym_off_phase", int'(bus.sym_valid), 0);
        end
      end else if (bus.sym_valid) begin
        sv_seen = 1;
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        if (bus.sym_valid) sv_seen = 1;
      end
    end
    if (chk_ph != -1) check_eq("no_stray_sym", sv_seen, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      si[i] = int'($urandom_range(0, 3));
      sq[i] = int'($urandom_range(0, 3));
    end
    bus.en = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_I = '0;
    bus.din_Q = '0;

    // Reset state, observed before the first clock edge
    #2 rst = 1'b1;
    #1;
    check_eq("rst_locked", int'(bus.locked), 0);
    check_eq("rst_sym_valid", int'(bus.sym_valid), 0);
    check_eq("rst_relock", int'(bus.relock_cnt), 0);
    check_eq("rst_err", int'(bus.err_metric), 0);
    check_eq("rst_best", int'(bus.best_phase), 0);
    do_reset();

    // Clean lock on phase 2
    start_acq();
    run_stream(M_CLEAN, 256, 0, -2);
    check_eq("s1_decide_pending", int'(bus.locked), 0);
    run_stream(M_CLEAN, 1, 0, -1);
    check_eq("s1_locked", int'(bus.locked), 1);
    check_eq("s1_best", int'(bus.best_phase), 2);
    check_eq("s1_err", int'(bus.err_metric), 0);
    check_eq("s1_relock", int'(bus.relock_cnt), 0);
    run_stream(M_CLEAN, 128, 0, 2);

    // Same stream, one valid in three cycles
    do_reset();
    start_acq();
    run_stream(M_CLEAN, 256, 2, -2);
    run_stream(M_CLEAN, 1, 2, -1);
    check_eq("s5_locked", int'(bus.locked), 1);
    check_eq("s5_best", int'(bus.best_phase), 2);
    run_stream(M_CLEAN, 128, 2, 2);

    // Equal error on every phase resolves to phase 0
    do_reset();
    start_acq();
    run_stream(M_TIE, 256, 0, -2);
    run_stream(M_TIE, 1, 0, -1);
    check_eq("s2_locked", int'(bus.locked), 1);
    check_eq("s2_best", int'(bus.best_phase), 0);
    check_eq("s2_err", int'(bus.err_metric), 0);
    run_stream(M_TIE, 16, 0, 0);

    // Lock loss after a full window of +-1296 on the locked phase
    do_reset();
    start_acq();
    run_stream(M_CLEAN, 257, 0, -1);
    check_eq("s4_locked", int'(bus.locked), 1);
    run_stream(M_BAD, 253, 0, 2);
    check_eq("s4_lock_held", int'(bus.locked), 1);
    run_stream(M_BAD, 1, 0, 2);
    check_eq("s4_unlocked", int'(bus.locked), 0);
    check_eq("s4_relock", int'(bus.relock_cnt), 1);
    check_eq("s4_err", int'(bus.err_metric), 1295);
    run_stream(M_CLEAN, 256, 0, -2);
    run_stream(M_CLEAN, 1, 0, -1);
    check_eq("s4_relocked", int'(bus.locked), 1);
    check_eq("s4_rebest", int'(bus.best_phase), 2);
    check_eq("s4_relock_kept", int'(bus.relock_cnt), 1);
    check_eq("s4_reerr", int'(bus.err_metric), 0);

    // en drop from LOCK, then all-zero input never locks
    bus.en = 1'b0;
    tick();
    check_eq("s6_idle_locked", int'(bus.locked), 0);
    check_eq("s6_idle_sym", int'(bus.sym_valid), 0);
    check_eq("s6_idle_relock", int'(bus.relock_cnt), 1);
    start_acq();
    run_stream(M_ZERO, 256, 0, -2);
    run_stream(M_ZERO, 1, 0, -1);
    check_eq("s3_locked", int'(bus.locked), 0);
    check_eq("s3_err", int'(bus.err_metric), 1296);
    run_stream(M_ZERO, 343, 0, -2);
    check_eq("s3_locked_again", int'(bus.locked), 0);
    check_eq("s3_err_again", int'(bus.err_metric), 1296);

    // en drop mid-ACQ must clear the partial accumulators
    bus.en = 1'b0;
    tick();
    check_eq("s6_acq_locked", int'(bus.locked), 0);
    check_eq("s6_acq_relock", int'(bus.relock_cnt), 1);
    check_eq("s6_acq_err_held", int'(bus.err_metric), 1296);
    start_acq();
    run_stream(M_CLEAN, 256, 0, -2);
    run_stream(M_CLEAN, 1, 0, -1);
    check_eq("s6_fresh_locked", int'(bus.locked), 1);
    check_eq("s6_fresh_err", int'(bus.err_metric), 0);
    check_eq("s6_fresh_best", int'(bus.best_phase), 2);

    // Async reset between edges while a strobe is high
    run_stream(M_CLEAN, 2, 0, 2);
    check_eq("s6_pre_relock", int'(bus.relock_cnt), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("s6_arst_locked", int'(bus.locked), 0);
    check_eq("s6_arst_sym_valid", int'(bus.sym_valid), 0);
    check_eq("s6_arst_relock", int'(bus.relock_cnt), 0);
    check_eq("s6_arst_err", int'(bus.err_metric), 0);
    check_eq("s6_arst_slice", int'(bus.slice_I), 0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
